instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Consumer side of the program counter: takes the current PC, issues one instruction-memory read per PC, and returns the fetched word to decode.
- Drives pc_write back to the PC register, so the PC advances only when a fetch completes or a redirect occurs.
- One outstanding memory request; sits between program_counter, instruction memory and the decode stage.

Parameters:
- XLEN, 32, width of PC, address and instruction.
- NOP_INST, 32'h0000_0013, value held on inst while empty or after reset.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- pc  input  XLEN  current PC from program counter
- pc_write  output  1  one-cycle pulse: PC loads next_pc (next_pc mux is external; selects target when redirect=1, else pc+4)
- redirect  input  1  one-cycle pulse from execute: taken branch/jump
- mem_req_valid  output  1  read request valid
- mem_req_ready  input  1  memory accepts request
- mem_req_addr  output  XLEN  read address (= pc)
- mem_rsp_valid  input  1  read data valid, exactly one per accepted request, at least 1 cycle after acceptance
- mem_rsp_data  input  XLEN  read data
- inst_valid  output  1  instruction available to decode
- inst_ready  input  1  decode accepts instruction
- inst  output  XLEN  fetched instruction
- inst_pc  output  XLEN  PC of inst

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset).
- Reset: state=S_REQ, discard=0, inst_valid=0, inst=NOP_INST, inst_pc=0.
  - mem_req_valid=0 and pc_write=0 while reset is high.
  - The memory shares reset and abandons in-flight requests.
- Output timing:
  - inst, inst_pc and inst_valid are registered.
  - mem_req_valid, mem_req_addr and pc_write are combinational from state and inputs.
- FSM S_REQ:
  - mem_req_valid = !redirect; mem_req_addr = pc.
  - On mem_req_valid && mem_req_ready -> S_WAIT.
- FSM S_WAIT:
  - mem_req_valid=0.
  - On mem_rsp_valid with discard=0: inst<=mem_rsp_data, inst_pc<=pc, inst_valid<=1, pc_write=1 that cycle, -> S_HOLD.
  - On mem_rsp_valid with discard=1: drop data, clear discard, -> S_REQ; no pc_write.
- FSM S_HOLD:
  - inst_valid held, inst and inst_pc stable.
  - On inst_valid && inst_ready: inst_valid<=0, -> S_REQ.
  - No new request is issued while in S_HOLD.
- Latency: request accepted in cycle N, response in N+k; inst_valid rises N+k+1, and the next request can start in N+k+2 at the earliest.
- Redirect (pc_write=1 in the redirect cycle in every state):
  - S_REQ: request suppressed that cycle; stay S_REQ, fetch the target next cycle.
  - S_WAIT without mem_rsp_valid: discard<=1.
  - S_WAIT with mem_rsp_valid the same cycle: the response is dropped; a single pc_write pulse (the redirect wins); -> S_REQ.
  - S_HOLD: inst_valid<=0 even if inst_ready=1 that cycle; the instruction is not considered consumed; -> S_REQ.
- pc_write is never asserted twice in one cycle and never asserted while reset is high.
- A redirect during reset is ignored.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- When defined:
  - Adds output fetch_fault (1 bit).
  - In S_REQ, if pc[1:0]!=0: no request is issued; the block loads inst=NOP_INST, inst_pc=pc, inst_valid=1 and fetch_fault=1, and goes to S_HOLD.
  - No pc_write is issued; execute must redirect.
  - fetch_fault clears with the inst handshake or a redirect.
- When undefined: pc[1:0] is ignored and the address is passed through unchanged.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {S_REQ, S_WAIT, S_HOLD}.
  - NOP_INST constant.
  - XLEN default.
- No sub-module is natural; single module.

Test Plan:
- Reset, pc=0x1000, memory ready at once, 1-cycle response 0x00500093 -> request addr 0x1000; one pc_write pulse; inst=0x00500093, inst_pc=0x1000.
- Back-to-back fetches 0x1000, 0x1004, 0x1008 with inst_ready=1 -> exactly 3 pc_write pulses; inst_pc sequence 0x1000, 0x1004, 0x1008 in order.
- inst_ready held low for 5 cycles in S_HOLD -> inst and inst_pc stable; mem_req_valid=0 throughout; no pc_write.
- Redirect to 0x2000 while in S_WAIT, stale response 0xDEADBEEF arrives 3 cycles later -> data dropped; next request addr 0x2000; inst_pc=0x2000.
- Redirect in the same cycle as mem_rsp_valid, and separately in S_HOLD with inst_ready=1 -> single pc_write each time; inst_valid low next cycle; next fetch from target.
- Reset asserted in S_WAIT -> next cycle inst_valid=0, inst=0x13, mem_req_valid=0 while reset is high; after release, request at 0x1000. With FETCH_MISALIGN_TRAP_EN defined, pc=0x1002 -> fetch_fault=1, no memory request, no pc_write.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch unit.
//   XLEN_DEFAULT     : default width of PC, address and instruction
//   NOP_INST_DEFAULT : instruction presented to decode while nothing is fetched
//   fetch_state_t    : fetch FSM states (request / wait for data / hold for decode)
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int          XLEN_DEFAULT     = 32;
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Issues one instruction-memory read per PC value, returns the fetched word to
// decode and pulses pc_write so the external PC register advances only when a
// fetch completes or execute redirects. At most one request is outstanding.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   pc                  : current PC from the program counter
//   pc_write            : one-cycle PC load pulse (combinational)
//   redirect            : one-cycle taken branch/jump pulse from execute
//   mem_req_*           : read request channel (valid/ready, addr = pc)
//   mem_rsp_*           : read response (one per accepted request)
//   inst_valid/ready    : handshake towards decode (registered valid)
//   inst, inst_pc       : fetched instruction and its PC (registered)
//   fetch_fault         : misaligned-PC fault flag (FETCH_MISALIGN_TRAP_EN only)
//
// Build option: define FETCH_MISALIGN_TRAP_EN to trap PCs with pc[1:0] != 0
// instead of passing them to memory unchanged.
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INST = XLEN'(NOP_INST_DEFAULT)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    output logic            pc_write,
    input  logic            redirect,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            fetch_fault
`endif
);

    fetch_state_t    state_r, state_s;
    logic            discard_r, discard_s;
    logic            inst_valid_r, inst_valid_s;
    logic [XLEN-1:0] inst_r, inst_s;
    logic [XLEN-1:0] inst_pc_r, inst_pc_s;
    logic            req_valid_s;
    logic            pc_write_s;
    logic            misalign_s;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            fault_r, fault_s;

    assign misalign_s  = (pc[1:0] != 2'b00);
    assign fetch_fault = fault_r;
`else
    assign misalign_s  = 1'b0;
`endif

    // Next-state, request and pc_write decode for the fetch FSM
    always_comb begin
        state_s      = state_r;
        discard_s    = discard_r;
        inst_valid_s = inst_valid_r;
        inst_s       = inst_r;
        inst_pc_s    = inst_pc_r;
        req_valid_s  = 1'b0;
        // A redirect always loads the PC; the fetch-complete load below never
        // coincides with it, so only one pulse can be produced per cycle.
        pc_write_s   = redirect;
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_s      = fault_r;
`endif
        case (state_r)
            S_REQ: begin
                if (redirect) begin
                    // Request suppressed; the target is fetched next cycle.
                    state_s = S_REQ;
                end else if (misalign_s) begin
                    // Present a faulting NOP without touching memory or the PC.
                    inst_s       = NOP_INST;
                    inst_pc_s    = pc;
                    inst_valid_s = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
                    fault_s      = 1'b1;
`endif
                    state_s      = S_HOLD;
                end else begin
                    req_valid_s = 1'b1;
                    if (mem_req_ready) begin
                        state_s = S_WAIT;
                    end else begin
                        state_s = S_REQ;
                    end
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid && !redirect && !discard_r) begin
                    // pc still holds the requested address until this pulse.
                    inst_s       = mem_rsp_data;
                    inst_pc_s    = pc;
                    inst_valid_s = 1'b1;
                    pc_write_s   = 1'b1;
                    state_s      = S_HOLD;
                end else if (mem_rsp_valid) begin
                    // Stale data (earlier or same-cycle redirect) is dropped.
                    discard_s = 1'b0;
                    state_s   = S_REQ;
                end else if (redirect) begin
                    discard_s = 1'b1;
                end else begin
                    discard_s = discard_r;
                end
            end
            S_HOLD: begin
                // A redirect flushes the instruction even if decode takes it.
                if (redirect || (inst_valid_r && inst_ready)) begin
                    inst_valid_s = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                    fault_s      = 1'b0;
`endif
                    state_s      = S_REQ;
                end else begin
                    state_s = S_HOLD;
                end
            end
            default: begin
                state_s = S_REQ;
            end
        endcase
    end

    // Fetch state and decode-facing output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_REQ;
            discard_r    <= 1'b0;
            inst_valid_r <= 1'b0;
            inst_r       <= NOP_INST;
            inst_pc_r    <= {XLEN{1'b0}};
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_r      <= 1'b0;
`endif
        end else begin
            state_r      <= state_s;
            discard_r    <= discard_s;
            inst_valid_r <= inst_valid_s;
            inst_r       <= inst_s;
            inst_pc_r    <= inst_pc_s;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_r      <= fault_s;
`endif
        end
    end

    // Requests and PC loads are silenced while reset is held.
    assign mem_req_valid = req_valid_s & ~reset;
    assign pc_write      = pc_write_s & ~reset;
    assign mem_req_addr  = pc;
    assign inst_valid    = inst_valid_r;
    assign inst          = inst_r;
    assign inst_pc       = inst_pc_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Self-checking bench for instr_fetch_unit. Surrounds the DUT with a PC
// register (next_pc mux: redirect target or pc+4), a memory with programmable
// latency, and a monitor that records consumed instructions. Directed tasks
// cover the listed scenarios; a randomized task compares the consumed stream
// against the program-order model: next PC is previous+4, or the most recent
// redirect target, and every word equals the memory content at its PC.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] pc;
    logic         pc_write;
    logic         redirect;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [W-1:0] mem_req_addr;
    logic         mem_rsp_valid;
    logic [W-1:0] mem_rsp_data;
    logic         inst_valid;
    logic         inst_ready;
    logic [W-1:0] inst;
    logic [W-1:0] inst_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic         fetch_fault;
`endif

    logic [W-1:0] redirect_target;
    logic [W-1:0] pc_reset_val;
    int unsigned  mem_lat;
    logic         override_en;
    logic [W-1:0] override_data;

    int compared   = 0;
    int mismatched = 0;

    int pc_write_cnt = 0;
    int fill_cnt     = 0;
    int accept_cnt   = 0;
    int proto_err    = 0;
    logic [W-1:0] acc_addr_q[$];
    logic [W-1:0] cons_pc_q[$];
    logic [W-1:0] cons_inst_q[$];

    logic         busy;
    int unsigned  cnt;
    logic [W-1:0] pend_data;
    logic         inst_valid_d;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc),
        .pc_write      (pc_write),
        .redirect      (redirect),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_fault   (fetch_fault)
`endif
    );

    function automatic logic [W-1:0] mem_data(input logic [W-1:0] a);
        if (a == 32'h0000_1000) return 32'h0050_0093;
        return (a * 32'd2654435761) ^ 32'h0000_0013;
    endfunction

    // External PC register with its next_pc mux
    always @(posedge clk) begin
        if (reset) pc <= pc_reset_val;
        else if (pc_write) pc <= redirect ? redirect_target : pc + 32'd4;
    end

    // Instruction memory: accepts one request, answers mem_lat cycles later
    always @(posedge clk) begin
        logic [W-1:0] d;
        if (reset) begin
            busy          <= 1'b0;
            mem_rsp_valid <= 1'b0;
            mem_rsp_data  <= 32'h0;
        end else begin
            mem_rsp_valid <= 1'b0;
            if (busy) begin
                if (cnt == 1) begin
                    mem_rsp_valid <= 1'b1;
                    mem_rsp_data  <= pend_data;
                    busy          <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
            if (mem_req_valid && mem_req_ready) begin
                d = override_en ? override_data : mem_data(mem_req_addr);
                accept_cnt <= accept_cnt + 1;
                acc_addr_q.push_back(mem_req_addr);
                if (busy || mem_rsp_valid) proto_err <= proto_err + 1;
                if (mem_lat <= 1) begin
                    mem_rsp_valid <= 1'b1;
                    mem_rsp_data  <= d;
                end else begin
                    busy      <= 1'b1;
                    cnt       <= mem_lat - 1;
                    pend_data <= d;
                end
            end
        end
    end

    // Monitor: pc_write pulses, instruction fills and consumed instructions
    always @(posedge clk) begin
        if (reset) begin
            inst_valid_d <= 1'b0;
        end else begin
            inst_valid_d <= inst_valid;
            if (pc_write) pc_write_cnt <= pc_write_cnt + 1;
            if (inst_valid && !inst_valid_d) fill_cnt <= fill_cnt + 1;
            if (inst_valid && inst_ready && !redirect) begin
                cons_pc_q.push_back(inst_pc);
                cons_inst_q.push_back(inst);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset with a given start PC; returns in the first cycle after release.
    task automatic do_reset(input logic [W-1:0] start);
        reset        = 1'b1;
        pc_reset_val = start;
        redirect     = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        acc_addr_q.delete();
        cons_pc_q.delete();
        cons_inst_q.delete();
    endtask

    task automatic wait_inst_valid(input int budget);
        int n = 0;
        while (inst_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; pc_reset_val = 32'h1000; redirect = 1'b1; redirect_target = 32'h2000;
        mem_req_ready = 1'b1; inst_ready = 1'b0; mem_lat = 1; override_en = 1'b0;
        tick();
        tick();
        #1;
        compared++; if (inst_valid !== 1'b0) begin mismatched++; $display("FAIL reset_inst_valid: got %0b want 0", inst_valid); end
        compared++; if (inst !== 32'h13) begin mismatched++; $display("FAIL reset_inst: got %h want 00000013", inst); end
        compared++; if (inst_pc !== 32'h0) begin mismatched++; $display("FAIL reset_inst_pc: got %h want 0", inst_pc); end
        compared++; if (mem_req_valid !== 1'b0) begin mismatched++; $display("FAIL reset_req_valid: got %0b want 0", mem_req_valid); end
        compared++; if (pc_write !== 1'b0) begin mismatched++; $display("FAIL reset_pc_write: got %0b want 0 (redirect during reset)", pc_write); end
        redirect = 1'b0;
    endtask

    task automatic test_single_fetch();
        int n = 0;
        int pw0;
        mem_req_ready = 1'b1; mem_lat = 1; inst_ready = 1'b0;
        do_reset(32'h1000);
        pw0 = pc_write_cnt;
        #1;
        compared++; if (mem_req_valid !== 1'b1) begin mismatched++; $display("FAIL single_req_valid: got %0b want 1", mem_req_valid); end
        compared++; if (mem_req_addr !== 32'h1000) begin mismatched++; $display("FAIL single_req_addr: got %h want 00001000", mem_req_addr); end
        while (inst_valid !== 1'b1 && n < 20) begin tick(); n++; end
        compared++; if (n !== 2) begin mismatched++; $display("FAIL single_latency: inst_valid after %0d cycles want 2", n); end
        compared++; if (inst !== 32'h0050_0093) begin mismatched++; $display("FAIL single_inst: got %h want 00500093", inst); end
        compared++; if (inst_pc !== 32'h1000) begin mismatched++; $display("FAIL single_inst_pc: got %h want 00001000", inst_pc); end
        compared++; if (pc_write_cnt - pw0 !== 1) begin mismatched++; $display("FAIL single_pc_write: got %0d pulses want 1", pc_write_cnt - pw0); end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0; mem_req_ready = 1'b0;
        compared++; if (cons_pc_q.size() !== 1) begin mismatched++; $display("FAIL single_consume: got %0d want 1", cons_pc_q.size()); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int pw0;
        mem_req_ready = 1'b1; mem_lat = 1; inst_ready = 1'b1;
        do_reset(32'h1000);
        pw0 = pc_write_cnt;
        while (cons_pc_q.size() < 3 && n < 50) begin tick(); n++; end
        mem_req_ready = 1'b0; inst_ready = 1'b0;
        compared++; if (cons_pc_q.size() !== 3) begin mismatched++; $display("FAIL b2b_count: got %0d want 3", cons_pc_q.size()); end
        compared++; if (pc_write_cnt - pw0 !== 3) begin mismatched++; $display("FAIL b2b_pc_write: got %0d want 3", pc_write_cnt - pw0); end
        for (int i = 0; i < 3; i++) begin
            logic [W-1:0] ep;
            ep = 32'h1000 + 32'(4 * i);
            if (i < cons_pc_q.size()) begin
                compared++; if (cons_pc_q[i] !== ep) begin mismatched++; $display("FAIL b2b_pc[%0d]: got %h want %h", i, cons_pc_q[i], ep); end
                compared++; if (cons_inst_q[i] !== mem_data(ep)) begin mismatched++; $display("FAIL b2b_inst[%0d]: got %h want %h", i, cons_inst_q[i], mem_data(ep)); end
            end
        end
    endtask

    task automatic test_hold_stall();
        int pw0;
        int a0;
        mem_req_ready = 1'b1; mem_lat = 2; inst_ready = 1'b0;
        do_reset(32'h1000);
        wait_inst_valid(20);
        compared++; if (inst_valid !== 1'b1) begin mismatched++; $display("FAIL hold_fill: inst_valid got %0b want 1", inst_valid); end
        pw0 = pc_write_cnt; a0 = accept_cnt;
        for (int c = 0; c < 5; c++) begin
            tick();
            compared++; if (inst_valid !== 1'b1) begin mismatched++; $display("FAIL hold_valid c%0d: got %0b want 1", c, inst_valid); end
            compared++; if (inst !== 32'h0050_0093) begin mismatched++; $display("FAIL hold_inst c%0d: got %h want 00500093", c, inst); end
            compared++; if (inst_pc !== 32'h1000) begin mismatched++; $display("FAIL hold_inst_pc c%0d: got %h want 00001000", c, inst_pc); end
            compared++; if (mem_req_valid !== 1'b0) begin mismatched++; $display("FAIL hold_req_valid c%0d: got %0b want 0", c, mem_req_valid); end
        end
        compared++; if (pc_write_cnt - pw0 !== 0) begin mismatched++; $display("FAIL hold_pc_write: got %0d want 0", pc_write_cnt - pw0); end
        compared++; if (accept_cnt - a0 !== 0) begin mismatched++; $display("FAIL hold_accepts: got %0d want 0", accept_cnt - a0); end
        mem_req_ready = 1'b0;
    endtask

    task automatic test_redirect_in_wait();
        int pw0;
        mem_req_ready = 1'b1; mem_lat = 4; inst_ready = 1'b1;
        override_en = 1'b1; override_data = 32'hDEAD_BEEF;
        do_reset(32'h1000);
        pw0 = pc_write_cnt;
        tick();
        override_en = 1'b0; mem_lat = 1;
        redirect = 1'b1; redirect_target = 32'h2000;
        #1;
        compared++; if (pc_write !== 1'b1) begin mismatched++; $display("FAIL rwait_pc_write: got %0b want 1", pc_write); end
        tick();
        redirect = 1'b0;
        wait_inst_valid(30);
        compared++; if (inst_valid !== 1'b1) begin mismatched++; $display("FAIL rwait_fill: inst_valid got %0b want 1", inst_valid); end
        compared++; if (inst_pc !== 32'h2000) begin mismatched++; $display("FAIL rwait_inst_pc: got %h want 00002000", inst_pc); end
        compared++; if (inst !== mem_data(32'h2000)) begin mismatched++; $display("FAIL rwait_inst: got %h want %h", inst, mem_data(32'h2000)); end
        compared++; if (acc_addr_q.size() !== 2) begin mismatched++; $display("FAIL rwait_requests: got %0d want 2", acc_addr_q.size()); end
        if (acc_addr_q.size() >= 2) begin
            compared++; if (acc_addr_q[1] !== 32'h2000) begin mismatched++; $display("FAIL rwait_req_addr: got %h want 00002000", acc_addr_q[1]); end
        end
        compared++; if (pc_write_cnt - pw0 !== 2) begin mismatched++; $display("FAIL rwait_pulses: got %0d want 2", pc_write_cnt - pw0); end
        mem_req_ready = 1'b0; inst_ready = 1'b0;
    endtask

    task automatic test_redirect_same_cycle();
        int n = 0;
        int pw0;
        mem_req_ready = 1'b1; mem_lat = 2; inst_ready = 1'b1;
        do_reset(32'h1000);
        pw0 = pc_write_cnt;
        while (mem_rsp_valid !== 1'b1 && n < 20) begin tick(); n++; end
        redirect = 1'b1; redirect_target = 32'h3000;
        #1;
        compared++; if (pc_write !== 1'b1) begin mismatched++; $display("FAIL rsame_pc_write: got %0b want 1", pc_write); end
        tick();
        redirect = 1'b0;
        compared++; if (inst_valid !== 1'b0) begin mismatched++; $display("FAIL rsame_inst_valid: got %0b want 0", inst_valid); end
        compared++; if (pc_write_cnt - pw0 !== 1) begin mismatched++; $display("FAIL rsame_pulses: got %0d want 1", pc_write_cnt - pw0); end
        wait_inst_valid(30);
        compared++; if (inst_pc !== 32'h3000) begin mismatched++; $display("FAIL rsame_inst_pc: got %h want 00003000", inst_pc); end
        compared++; if (inst !== mem_data(32'h3000)) begin mismatched++; $display("FAIL rsame_inst: got %h want %h", inst, mem_data(32'h3000)); end
        mem_req_ready = 1'b0; inst_ready = 1'b0;
    endtask

    task automatic test_redirect_in_hold();
        int pw0;
        int c0;
        mem_req_ready = 1'b1; mem_lat = 1; inst_ready = 1'b0;
        do_reset(32'h1000);
        wait_inst_valid(20);
        pw0 = pc_write_cnt; c0 = cons_pc_q.size();
        inst_ready = 1'b1; redirect = 1'b1; redirect_target = 32'h4000;
        #1;
        compared++; if (pc_write !== 1'b1) begin mismatched++; $display("FAIL rhold_pc_write: got %0b want 1", pc_write); end
        tick();
        redirect = 1'b0; inst_ready = 1'b0;
        compared++; if (inst_valid !== 1'b0) begin mismatched++; $display("FAIL rhold_inst_valid: got %0b want 0", inst_valid); end
        compared++; if (cons_pc_q.size() !== c0) begin mismatched++; $display("FAIL rhold_consumed: got %0d want %0d", cons_pc_q.size(), c0); end
        compared++; if (pc_write_cnt - pw0 !== 1) begin mismatched++; $display("FAIL rhold_pulses: got %0d want 1", pc_write_cnt - pw0); end
        wait_inst_valid(20);
        compared++; if (inst_pc !== 32'h4000) begin mismatched++; $display("FAIL rhold_inst_pc: got %h want 00004000", inst_pc); end
        compared++; if (inst !== mem_data(32'h4000)) begin mismatched++; $display("FAIL rhold_inst: got %h want %h", inst, mem_data(32'h4000)); end
        mem_req_ready = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        int n = 0;
        mem_req_ready = 1'b1; mem_lat = 3; inst_ready = 1'b1;
        do_reset(32'h1000);
        while (cons_pc_q.size() < 1 && n < 30) begin tick(); n++; end
        tick();
        reset = 1'b1;
        #1;
        compared++; if (mem_req_valid !== 1'b0) begin mismatched++; $display("FAIL rstw_req_valid0: got %0b want 0", mem_req_valid); end
        compared++; if (pc_write !== 1'b0) begin mismatched++; $display("FAIL rstw_pc_write: got %0b want 0", pc_write); end
        tick();
        compared++; if (inst_valid !== 1'b0) begin mismatched++; $display("FAIL rstw_inst_valid: got %0b want 0", inst_valid); end
        compared++; if (inst !== 32'h13) begin mismatched++; $display("FAIL rstw_inst: got %h want 00000013", inst); end
        compared++; if (inst_pc !== 32'h0) begin mismatched++; $display("FAIL rstw_inst_pc: got %h want 0", inst_pc); end
        compared++; if (mem_req_valid !== 1'b0) begin mismatched++; $display("FAIL rstw_req_valid1: got %0b want 0", mem_req_valid); end
        tick();
        reset = 1'b0;
        acc_addr_q.delete(); cons_pc_q.delete(); cons_inst_q.delete();
        #1;
        compared++; if (mem_req_valid !== 1'b1) begin mismatched++; $display("FAIL rstw_restart_valid: got %0b want 1", mem_req_valid); end
        compared++; if (mem_req_addr !== 32'h1000) begin mismatched++; $display("FAIL rstw_restart_addr: got %h want 00001000", mem_req_addr); end
        mem_req_ready = 1'b0; inst_ready = 1'b0;
    endtask

`ifdef FETCH_MISALIGN_TRAP_EN
    task automatic test_misalign();
        int pw0;
        int a0;
        mem_req_ready = 1'b1; mem_lat = 1; inst_ready = 1'b0;
        do_reset(32'h1002);
        pw0 = pc_write_cnt; a0 = accept_cnt;
        #1;
        compared++; if (mem_req_valid !== 1'b0) begin mismatched++; $display("FAIL mis_req_valid: got %0b want 0", mem_req_valid); end
        tick();
        compared++; if (fetch_fault !== 1'b1) begin mismatched++; $display("FAIL mis_fault: got %0b want 1", fetch_fault); end
        compared++; if (inst_valid !== 1'b1) begin mismatched++; $display("FAIL mis_inst_valid: got %0b want 1", inst_valid); end
        compared++; if (inst_pc !== 32'h1002) begin mismatched++; $display("FAIL mis_inst_pc: got %h want 00001002", inst_pc); end
        compared++; if (inst !== 32'h13) begin mismatched++; $display("FAIL mis_inst: got %h want 00000013", inst); end
        tick();
        compared++; if (accept_cnt - a0 !== 0) begin mismatched++; $display("FAIL mis_accepts: got %0d want 0", accept_cnt - a0); end
        compared++; if (pc_write_cnt - pw0 !== 0) begin mismatched++; $display("FAIL mis_pc_write: got %0d want 0", pc_write_cnt - pw0); end
        redirect = 1'b1; redirect_target = 32'h1000;
        tick();
        redirect = 1'b0;
        compared++; if (fetch_fault !== 1'b0) begin mismatched++; $display("FAIL mis_fault_clear: got %0b want 0", fetch_fault); end
        compared++; if (inst_valid !== 1'b0) begin mismatched++; $display("FAIL mis_flush: got %0b want 0", inst_valid); end
        mem_req_ready = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic [W-1:0] exp_pc;
        logic [W-1:0] p;
        logic [W-1:0] d;
        logic [W-1:0] tgt;
        logic         red;
        int nred = 0;
        int ncons = 0;
        int pw0;
        int f0;
        mem_req_ready = 1'b0; inst_ready = 1'b0; mem_lat = 1;
        do_reset(32'h0000_8000);
        exp_pc = 32'h0000_8000;
        pw0 = pc_write_cnt; f0 = fill_cnt;
        for (int cyc = 0; cyc < 800; cyc++) begin
            mem_req_ready   = ($urandom_range(0, 99) < 60);
            inst_ready      = ($urandom_range(0, 99) < 60);
            mem_lat         = $urandom_range(1, 4);
            red             = ($urandom_range(0, 99) < 6);
            tgt             = ($urandom() & 32'h0000_FFFC) | 32'h0001_0000;
            redirect        = red;
            redirect_target = tgt;
            tick();
            while (cons_pc_q.size() > 0) begin
                p = cons_pc_q.pop_front();
                d = cons_inst_q.pop_front();
                compared++; if (p !== exp_pc) begin mismatched++; $display("FAIL rand_pc #%0d: got %h want %h", ncons, p, exp_pc); end
                compared++; if (d !== mem_data(exp_pc)) begin mismatched++; $display("FAIL rand_inst #%0d: got %h want %h", ncons, d, mem_data(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
                ncons++;
            end
            if (red) begin
                exp_pc = tgt;
                nred++;
            end
        end
        redirect = 1'b0; mem_req_ready = 1'b0; inst_ready = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        compared++; if (ncons < 1) begin mismatched++; $display("FAIL rand_progress: got %0d consumed want >0", ncons); end
        compared++; if (pc_write_cnt - pw0 !== nred + (fill_cnt - f0)) begin
            mismatched++; $display("FAIL rand_pc_write: got %0d want %0d", pc_write_cnt - pw0, nred + (fill_cnt - f0));
        end
        compared++; if (proto_err !== 0) begin mismatched++; $display("FAIL rand_one_outstanding: got %0d violations want 0", proto_err); end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_back_to_back();
        test_hold_stall();
        test_redirect_in_wait();
        test_redirect_same_cycle();
        test_redirect_in_hold();
        test_reset_in_wait();
`ifdef FETCH_MISALIGN_TRAP_EN
        test_misalign();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
